// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem request in flight and
// buffers returned {pc, instr} pairs in a small FIFO toward decode.
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] fetch_pc
);

  localparam int unsigned     PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW  = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [XLEN-1:0] r_req_pc, w_req_pc_d;
  logic [PtrW-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [PtrW-1:0] r_rd_ptr, w_rd_ptr_d;
  logic [CntW-1:0] r_count, w_count_d;
  logic [XLEN-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] r_instr_mem [FIFO_DEPTH];
  logic            w_push, w_pop;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = (r_state == StWait) && imem_rvalid && !redirect_valid;

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_req_pc_d   = r_req_pc;
    w_wr_ptr_d   = r_wr_ptr;
    w_rd_ptr_d   = r_rd_ptr;
    w_count_d    = r_count;

    if (w_push) w_wr_ptr_d = r_wr_ptr + PtrW'(1);
    if (w_pop)  w_rd_ptr_d = r_rd_ptr + PtrW'(1);
    if (w_push && !w_pop)      w_count_d = r_count + CntW'(1);
    else if (!w_push && w_pop) w_count_d = r_count - CntW'(1);

    case (r_state)
      StIdle: if (r_count < Depth) w_state_d = StReq;
      StReq: begin
        if (imem_gnt) begin
          w_req_pc_d   = r_fetch_pc;
          w_fetch_pc_d = r_fetch_pc + XLEN'(4);
          w_state_d    = StWait;
        end
      end
      StWait: if (imem_rvalid) w_state_d = (w_count_d < Depth) ? StReq : StIdle;
      StDrop: if (imem_rvalid) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Redirect wins over everything; an in-flight response still has to be drained in StDrop.
    if (redirect_valid) begin
      w_wr_ptr_d   = '0;
      w_rd_ptr_d   = '0;
      w_count_d    = '0;
      w_req_pc_d   = r_req_pc;
      w_fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      if ((r_state == StWait || r_state == StDrop) && !imem_rvalid) w_state_d = StDrop;
      else                                                          w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      r_req_pc   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_req_pc   <= w_req_pc_d;
      r_wr_ptr   <= w_wr_ptr_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_count    <= w_count_d;
    end
  end

  // Storage needs no reset: the head is masked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = (r_state == StReq);
  assign imem_addr = r_fetch_pc;
  assign fetch_pc  = r_fetch_pc;
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural imem plus a sequential-PC model of
// what decode must see, driven by hand sequences, a redirect table and random traffic.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, fetch_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fetch_pc      (fetch_pc)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          gnt_pct = 100;
  int          lat_fix = 1;
  logic [31:0] exp_pc = '0;
  bit          expect_empty = 1'b0;
  bit          hold_req = 1'b0;
  logic [31:0] hold_addr = '0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_delay = 0;
  bit          req_seen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] pc2;
  } redir_vec_t;
  redir_vec_t tbl[5];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] popped(input int i);
    return (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  // One cycle: check outputs at the negedge, drive inputs for the coming posedge, advance models.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit rv, gn, pop;
    if (expect_empty) check("empty_after_redirect", 32'(out_valid), 32'd0);
    expect_empty = 1'b0;
    if (!out_valid) begin
      check("empty_pc_zero", out_pc, 32'd0);
      check("empty_instr_zero", out_instr, 32'd0);
    end
    if (hold_req) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("req_addr_stable", imem_addr, hold_addr);
    end
    if (imem_req) begin
      check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
      if (!req_seen) begin
        req_seen = 1'b1;
        req_addr = imem_addr;
      end
    end
    rv  = pend && (pend_delay == 0);
    gn  = imem_req && !pend && (int'($urandom_range(99)) < gnt_pct);
    pop = out_valid && rdy;
    if (pop && !redir) begin
      check("out_pc", out_pc, exp_pc);
      check("out_instr", out_instr, exp_pc ^ KEY);
      pop_pc.push_back(out_pc);
      pop_cyc.push_back(cyc);
      n_pop++;
      exp_pc = exp_pc + 32'd4;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    imem_gnt       = gn;
    imem_rvalid    = rv;
    imem_rdata     = rv ? (pend_addr ^ KEY) : $urandom;
    if (rv) pend = 1'b0;
    else if (pend) pend_delay--;
    if (gn && !redir) begin
      pend       = 1'b1;
      pend_addr  = imem_addr;
      pend_delay = (lat_fix > 0) ? lat_fix - 1 : int'($urandom_range(3));
    end
    hold_req  = imem_req && !gn && !redir;
    hold_addr = imem_addr;
    if (redir) begin
      exp_pc       = {rpc[31:2], 2'b00};
      expect_empty = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    req_seen = 1'b0;
    pop_pc.delete();
    pop_cyc.delete();
  endtask

  task automatic apply_reset();
    reset          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    reset        = 1'b1;
    exp_pc       = '0;
    hold_req     = 1'b0;
    expect_empty = 1'b0;
    pend         = 1'b0;
    clear_obs();
  endtask

  initial begin
    int pop0;

    tbl[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    tbl[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    tbl[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tbl[4] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C, 32'h1234_5680};

    // Streaming fetch: request one cycle after reset release, 1 instruction per 2 cycles.
    apply_reset();
    check("a_req_idle", 32'(imem_req), 32'd0);
    step(0, '0, 1);
    check("a_req_first", 32'(imem_req), 32'd1);
    check("a_req_addr", imem_addr, 32'd0);
    repeat (20) step(0, '0, 1);
    for (int i = 0; i < 4; i++) check("a_pc_seq", popped(i), 32'(4 * i));
    if (pop_cyc.size() >= 4)
      for (int i = 0; i < 3; i++) check("a_throughput", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd2);
    else check("a_pop_count", 32'(pop_cyc.size()), 32'd4);

    // Backpressure: exactly four entries buffered, fetching resumes at 0x10.
    apply_reset();
    repeat (24) step(0, '0, 0);
    repeat (3) begin
      check("b_full_no_req", 32'(imem_req), 32'd0);
      step(0, '0, 0);
    end
    check("b_full_valid", 32'(out_valid), 32'd1);
    clear_obs();
    repeat (4) begin
      check("b_drain_valid", 32'(out_valid), 32'd1);
      step(0, '0, 1);
    end
    for (int i = 0; i < 4; i++) check("b_pc_seq", popped(i), 32'(4 * i));
    if (pop_cyc.size() >= 4) check("b_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    repeat (6) step(0, '0, 1);
    check("b_resume_seen", 32'(req_seen), 32'd1);
    check("b_resume_addr", req_addr, 32'h10);

    // Redirect in WAIT with the response three cycles later: stale data never surfaces.
    apply_reset();
    lat_fix = 4;
    repeat (2) step(0, '0, 1);
    step(1, 32'h100, 1);
    clear_obs();
    repeat (2) begin
      check("c_drop_no_req", 32'(imem_req), 32'd0);
      step(0, '0, 1);
    end
    repeat (25) step(0, '0, 1);
    check("c_req_addr", req_addr, 32'h100);
    check("c_first_pc", popped(0), 32'h100);
    lat_fix = 1;

    // Redirect coinciding with a pop of a two-entry FIFO.
    apply_reset();
    repeat (5) step(0, '0, 0);
    check("d_two_valid", 32'(out_valid), 32'd1);
    check("d_head_pc", out_pc, 32'd0);
    step(1, 32'h203, 1);
    check("d_flush_valid", 32'(out_valid), 32'd0);
    check("d_fetch_pc", fetch_pc, 32'h200);
    clear_obs();
    repeat (8) step(0, '0, 1);
    check("d_req_addr", req_addr, 32'h200);
    check("d_first_pc", popped(0), 32'h200);

    // Redirect targets, including alignment and wrap past the top of the address space.
    for (int t = 0; t < 5; t++) begin
      step(1, tbl[t].rpc, 1);
      check("tbl_fetch_pc", fetch_pc, tbl[t].pc0);
      clear_obs();
      repeat (12) step(0, '0, 1);
      check("tbl_req_addr", req_addr, tbl[t].pc0);
      check("tbl_pc0", popped(0), tbl[t].pc0);
      check("tbl_pc1", popped(1), tbl[t].pc1);
      check("tbl_pc2", popped(2), tbl[t].pc2);
    end

    // Asynchronous reset mid-WAIT with a loaded FIFO, then a stale response.
    apply_reset();
    lat_fix = 4;
    repeat (18) step(0, '0, 0);
    check("f_loaded_valid", 32'(out_valid), 32'd1);
    check("f_in_wait", 32'(imem_req), 32'd0);
    #2;
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("f_async_valid", 32'(out_valid), 32'd0);
    check("f_async_pc", out_pc, 32'd0);
    check("f_async_instr", out_instr, 32'd0);
    check("f_async_fetch_pc", fetch_pc, 32'd0);
    @(negedge clk);
    reset        = 1'b1;
    exp_pc       = '0;
    hold_req     = 1'b0;
    expect_empty = 1'b0;
    pend_delay   = 0;
    lat_fix      = 1;
    clear_obs();
    step(0, '0, 1);
    repeat (20) step(0, '0, 1);
    check("f_req_addr", req_addr, 32'd0);
    check("f_first_pc", popped(0), 32'd0);
    check("f_first_instr_ok", 32'(pop_pc.size() >= 4), 32'd1);

    // Random traffic: variable grant rate and latency, backpressure and redirects.
    apply_reset();
    lat_fix = 0;
    pop0    = n_pop;
    begin
      bit prev_redir = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        bit          rd;
        logic [31:0] rpc;
        if (i % 250 == 0) gnt_pct = int'($urandom_range(30, 100));
        rd  = !prev_redir && ($urandom_range(99) < 3);
        rpc = $urandom;
        if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
        step(rd, rpc, $urandom_range(99) < 70);
        prev_redir = rd;
      end
    end
    check("random_progress", 32'((n_pop - pop0) > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
